uart_rx_push: RTL and testbench



---
 rtl/uart_rx_pkg.sv | 21 ++
 rtl/uart_rx_push_sync_ff.sv | 29 ++
 rtl/uart_rx_push.sv | 153 +++++++++++++++
 tb/tb_uart_rx_push.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the 8N1 UART receive front end.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  // Serial data arrives LSB first, so each new bit enters at the top.
  function automatic logic [DATA_BITS-1:0] shift_in(input logic [DATA_BITS-1:0] sr,
                                                     input logic              b);
    return {b, sr[DATA_BITS-1:1]};
  endfunction

endpackage

// File: rtl/uart_rx_push_sync_ff.sv
// Multi-flop synchroniser for a single asynchronous input; reset value selectable.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_push.sv
// 8N1 serial receiver that pushes each good byte into a downstream FIFO,
// flagging framing errors and bytes dropped on a full FIFO.
module uart_rx_push
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       full,
  input  logic       ovr_clr,
  output logic       wr,
  output logic [7:0] din,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

  logic rx_s;

  sync_ff #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 wr_q, wr_d;
  logic [7:0]           din_q, din_d;
  logic                 busy_q, busy_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 ovr_set;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    wr_d        = 1'b0;
    din_d       = din_q;
    frame_err_d = 1'b0;
    ovr_set     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        // Re-check the line at mid start bit; a high here was only a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = shift_in(shift_q, rx_s);
          if (bit_idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
            if (full) begin
              ovr_set = 1'b1;
            end else begin
              wr_d  = 1'b1;
              din_d = shift_q;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BREAK: begin
        // A line held low must go idle before another start bit is accepted.
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    overrun_d = ovr_set | (overrun_q & ~ovr_clr);
    busy_d    = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      wr_q        <= 1'b0;
      din_q       <= 8'h00;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      wr_q        <= wr_d;
      din_q       <= din_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign wr        = wr_q;
  assign din       = din_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_push.sv
// Directed bench for uart_rx_push with a 16-entry FIFO model on its write port.
module tb_uart_rx_push;

  localparam int CPB = 8;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       full;
  logic       ovr_clr;
  logic       wr;
  logic [7:0] din;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  uart_rx_push #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .full     (full),
    .ovr_clr  (ovr_clr),
    .wr       (wr),
    .din      (din),
    .busy     (busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  int n_assert = 0;
  int n_fail   = 0;

  int         cyc = 0;
  int         wr_count = 0;
  int         last_wr_cyc = 0;
  int         wr_back2back = 0;
  int         wr_while_full = 0;
  int         ferr_count = 0;
  int         busy_rises = 0;
  int         push_total = 0;
  int         pop_total = 0;
  logic [7:0] mem [0:255];

  assign full = ((push_total - pop_total) >= 16);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // FIFO model and event counters, sampled on the falling edge.
  initial begin
    logic prev_wr;
    logic prev_busy;
    prev_wr   = 1'b0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (wr === 1'b1) begin
        wr_count++;
        last_wr_cyc = cyc;
        if (prev_wr) wr_back2back++;
        if ((push_total - pop_total) < 16) begin
          mem[push_total % 256] = din;
          push_total++;
        end else begin
          wr_while_full++;
        end
      end
      prev_wr = (wr === 1'b1);
      if (frame_err === 1'b1) ferr_count++;
      if ((busy === 1'b1) && !prev_busy) busy_rises++;
      prev_busy = (busy === 1'b1);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_bit);
  endtask

  task automatic pop(output logic [7:0] v);
    v = mem[pop_total % 256];
    pop_total++;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr"}, {31'd0, wr}, 32'd0);
    chk({tag, "_din"}, {24'd0, din}, 32'h00);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
  endtask

  initial begin
    int         t0;
    int         wr0;
    int         fe0;
    int         br0;
    logic [7:0] v;
    logic [7:0] exp_b2b [3];

    rst     = 1'b1;
    rx      = 1'b1;
    ovr_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single byte: push ~79 cycles after the start edge.
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    repeat (2) @(negedge clk);
    chk("single_wr_count", wr_count, 1);
    chk("single_latency", last_wr_cyc - t0, 79);
    chk("single_fifo_cnt", push_total - pop_total, 1);
    chk("single_din_hold", {24'd0, din}, 32'hA5);
    chk("single_frame_err", ferr_count, 0);
    chk("single_overrun", {31'd0, overrun}, 32'd0);
    pop(v);
    chk("single_data", {24'd0, v}, 32'hA5);

    // Back-to-back frames, no idle gap.
    exp_b2b[0] = 8'h00;
    exp_b2b[1] = 8'hFF;
    exp_b2b[2] = 8'h3C;
    wr0 = wr_count;
    for (int i = 0; i < 3; i++) send_frame(exp_b2b[i], 1'b1);
    repeat (2) @(negedge clk);
    chk("b2b_wr_count", wr_count - wr0, 3);
    for (int i = 0; i < 3; i++) begin
      pop(v);
      chk($sformatf("b2b_data%0d", i), {24'd0, v}, {24'd0, exp_b2b[i]});
    end

    // Start glitch: 2-cycle low pulse.
    wr0 = wr_count;
    br0 = busy_rises;
    rx  = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (12) @(negedge clk);
    chk("glitch_busy_rose", busy_rises - br0, 1);
    chk("glitch_busy_idle", {31'd0, busy}, 32'd0);
    chk("glitch_no_wr", wr_count - wr0, 0);
    chk("glitch_no_ferr", ferr_count, 0);
    chk("glitch_no_ovr", {31'd0, overrun}, 32'd0);

    // Framing error followed by a held-low line, then a good byte.
    wr0 = wr_count;
    fe0 = ferr_count;
    send_frame(8'h55, 1'b0);
    repeat (30) @(negedge clk);
    chk("ferr_pulse", ferr_count - fe0, 1);
    chk("ferr_no_wr", wr_count - wr0, 0);
    chk("ferr_break_busy", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    chk("ferr_release_idle", {31'd0, busy}, 32'd0);
    chk("ferr_no_new_frame", wr_count - wr0, 0);
    send_frame(8'h12, 1'b1);
    repeat (2) @(negedge clk);
    chk("ferr_next_wr", wr_count - wr0, 1);
    pop(v);
    chk("ferr_next_data", {24'd0, v}, 32'h12);

    // Overrun: 17 bytes into an unread 16-entry FIFO.
    wr0 = wr_count;
    for (int i = 0; i < 17; i++) send_frame(8'h30 + 8'(i), 1'b1);
    repeat (2) @(negedge clk);
    chk("ovr_wr_count", wr_count - wr0, 16);
    chk("ovr_full", {31'd0, full}, 32'd1);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    chk("ovr_no_wr_when_full", wr_while_full, 0);
    for (int i = 0; i < 16; i++) begin
      pop(v);
      chk($sformatf("ovr_data%0d", i), {24'd0, v}, 32'h30 + i);
    end
    @(negedge clk);
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    @(negedge clk);
    chk("ovr_cleared", {31'd0, overrun}, 32'd0);

    // Reset during bit 4 of 0x81.
    wr0 = wr_count;
    fe0 = ferr_count;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(((8'h81 >> i) & 8'h01) != 0);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (16) @(negedge clk);
    chk("midrst_no_wr", wr_count - wr0, 0);
    send_frame(8'h7E, 1'b1);
    repeat (2) @(negedge clk);
    chk("midrst_next_wr", wr_count - wr0, 1);
    pop(v);
    chk("midrst_next_data", {24'd0, v}, 32'h7E);
    chk("midrst_no_ferr", ferr_count - fe0, 0);

    chk("wr_never_back2back", wr_back2back, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
